// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard that stalls the ID stage
// while a source operand's producer is still too far from write-back to be read
// or forwarded. Optional stall statistics counter under macro HAZARD_STATS_EN.
module hazard_scoreboard #(
   parameter  int unsigned REG_ADDR_W = 4,
   parameter  int unsigned NUM_SRC    = 3,
   parameter  int unsigned NOFW_LAT   = 2,
   parameter  int unsigned LOAD_LAT   = 1,
   localparam int unsigned NREG       = 2**REG_ADDR_W,
   localparam int unsigned CNT_W      = $clog2(NOFW_LAT + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          fw_en,
   input  logic                          issue_valid,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
   input  logic [NUM_SRC-1:0]            src_used,
   input  logic [REG_ADDR_W-1:0]         dest_addr,
   input  logic                          dest_wb_en,
   input  logic                          dest_is_load,
   input  logic                          pipe_freeze,
   input  logic                          flush,
   output logic                          hazard_detected,
   output logic                          issue_fire,
   output logic [NREG-1:0]               busy_vec,
   output logic [31:0]                   stall_cycles
);

   // A load result becomes forwardable once its countdown drops to this value
   localparam logic [CNT_W-1:0] LOAD_FW_CNT = CNT_W'(NOFW_LAT - LOAD_LAT);
   localparam logic [CNT_W-1:0] ISSUE_CNT   = CNT_W'(NOFW_LAT);

   logic [CNT_W-1:0] cnt [NREG];
   logic [NREG-1:0]  ld;
   logic [NREG-1:0]  pend;
   logic             src_hit;

   // Per-register "not yet readable" under the current forwarding mode
   always_comb begin
      pend = '0;
      for (int r = 0; r < NREG; r++) begin
         pend[r] = (cnt[r] != '0) && (!fw_en || (ld[r] && (cnt[r] > LOAD_FW_CNT)));
      end
   end

   // Any used source operand that hits a pending register
   always_comb begin
      src_hit = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (src_used[i] && pend[src_addr[i*REG_ADDR_W +: REG_ADDR_W]]) begin
            src_hit = 1'b1;
         end
      end
   end

   // Stall and advance decisions; advance is suppressed while reset is asserted
   always_comb begin
      hazard_detected = issue_valid & src_hit;
      issue_fire      = rst & issue_valid & ~src_hit & ~pipe_freeze & ~flush;
   end

   // Busy view of the scoreboard
   always_comb begin
      busy_vec = '0;
      for (int r = 0; r < NREG; r++) begin
         busy_vec[r] = (cnt[r] != '0);
      end
   end

   // Countdown per register; a new issue reloads its destination entry
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREG; r++) begin
            cnt[r] <= '0;
         end
         ld <= '0;
      end else if (!pipe_freeze) begin
         for (int r = 0; r < NREG; r++) begin
            if (cnt[r] != '0) begin
               cnt[r] <= cnt[r] - CNT_W'(1);
               if (cnt[r] == CNT_W'(1)) begin
                  ld[r] <= 1'b0;
               end
            end
         end
         if (issue_fire && dest_wb_en) begin
            cnt[dest_addr] <= ISSUE_CNT;
            ld[dest_addr]  <= dest_is_load;
         end
      end
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt;

   // Saturating count of cycles the ID stage spent stalled on a hazard
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (issue_valid && hazard_detected && !pipe_freeze && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table plus hand-written reset and
// stall-length sequences for hazard_scoreboard (default parameters).
module tb_hazard_scoreboard;

`ifdef HAZARD_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        fw_en;
   logic        issue_valid;
   logic [11:0] src_addr;
   logic [2:0]  src_used;
   logic [3:0]  dest_addr;
   logic        dest_wb_en;
   logic        dest_is_load;
   logic        pipe_freeze;
   logic        flush;
   logic        hazard_detected;
   logic        issue_fire;
   logic [15:0] busy_vec;
   logic [31:0] stall_cycles;

   hazard_scoreboard dut (
      .clk             (clk),
      .rst             (rst),
      .fw_en           (fw_en),
      .issue_valid     (issue_valid),
      .src_addr        (src_addr),
      .src_used        (src_used),
      .dest_addr       (dest_addr),
      .dest_wb_en      (dest_wb_en),
      .dest_is_load    (dest_is_load),
      .pipe_freeze     (pipe_freeze),
      .flush           (flush),
      .hazard_detected (hazard_detected),
      .issue_fire      (issue_fire),
      .busy_vec        (busy_vec),
      .stall_cycles    (stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst;
      logic        fw;
      logic        iv;
      logic [3:0]  s2;
      logic [3:0]  s1;
      logic [3:0]  s0;
      logic [2:0]  used;
      logic [3:0]  dest;
      logic        wb;
      logic        ld;
      logic        frz;
      logic        fl;
      logic        hz;
      logic        fire;
      logic [15:0] busy;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   stat_exp = 0;

   task automatic v(input logic r, input logic fw, input logic iv,
                    input logic [3:0] s2, input logic [3:0] s1, input logic [3:0] s0,
                    input logic [2:0] used, input logic [3:0] dest, input logic wb,
                    input logic ld, input logic frz, input logic fl,
                    input logic hz, input logic fire, input logic [15:0] busy);
      vec_t t;
      t.rst = r;  t.fw = fw;  t.iv = iv;
      t.s2 = s2;  t.s1 = s1;  t.s0 = s0;  t.used = used;
      t.dest = dest;  t.wb = wb;  t.ld = ld;  t.frz = frz;  t.fl = fl;
      t.hz = hz;  t.fire = fire;  t.busy = busy;
      vecs.push_back(t);
   endtask

   task automatic drive(input vec_t t);
      rst          = t.rst;
      fw_en        = t.fw;
      issue_valid  = t.iv;
      src_addr     = {t.s2, t.s1, t.s0};
      src_used     = t.used;
      dest_addr    = t.dest;
      dest_wb_en   = t.wb;
      dest_is_load = t.ld;
      pipe_freeze  = t.frz;
      flush        = t.fl;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Producer on r1, then a reader of r1 (operand 2) held until it fires
   task automatic stall_run(input logic fw, input logic is_ld, output int stalls, output bit timeout);
      vec_t t;
      t = '0;
      @(negedge clk);
      t.rst = 1'b1; t.fw = fw; t.iv = 1'b1; t.dest = 4'd1; t.wb = 1'b1; t.ld = is_ld;
      drive(t);
      @(negedge clk);
      t.wb = 1'b0; t.ld = 1'b0; t.dest = 4'd0; t.s2 = 4'd1; t.used = 3'b100;
      drive(t);
      stalls  = 0;
      timeout = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (issue_fire) begin
            timeout = 1'b0;
            break;
         end
         if (hazard_detected) stalls++;
         @(negedge clk);
      end
      @(negedge clk);
      t = '0; t.rst = 1'b1; t.fw = fw;
      drive(t);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t t;
      int   stalls;
      bit   tmo;

      // rst fw iv  s2 s1 s0 used   dest wb ld frz fl   hz fire busy
      v(0,0,0, 0,0,0,3'b000,  0,0,0,0,0, 0,0,16'h0000);
      v(0,0,1, 0,0,1,3'b001,  1,1,0,0,0, 0,0,16'h0000);
      // no forwarding: two stall cycles
      v(1,0,1, 0,0,0,3'b000,  1,1,0,0,0, 0,1,16'h0000);
      v(1,0,1, 0,0,1,3'b001,  8,1,0,0,0, 1,0,16'h0002);
      v(1,0,1, 0,0,1,3'b001,  8,1,0,0,0, 1,0,16'h0002);
      v(1,0,1, 0,0,1,3'b001,  8,1,0,0,0, 0,1,16'h0000);
      v(1,0,0, 0,0,0,3'b000,  0,0,0,0,0, 0,0,16'h0100);
      v(1,0,0, 0,0,0,3'b000,  0,0,0,0,0, 0,0,16'h0100);
      v(1,0,0, 0,0,0,3'b000,  0,0,0,0,0, 0,0,16'h0000);
      // load-use with forwarding, reader on operand 2
      v(1,1,1, 0,0,0,3'b000,  2,1,1,0,0, 0,1,16'h0000);
      v(1,1,1, 2,0,0,3'b100,  9,1,0,0,0, 1,0,16'h0004);
      v(1,1,1, 2,0,0,3'b100,  9,1,0,0,0, 0,1,16'h0004);
      v(1,1,0, 0,0,0,3'b000,  0,0,0,0,0, 0,0,16'h0200);
      // ALU producer with forwarding: no stall
      v(1,1,1, 0,0,0,3'b000,  3,1,0,0,0, 0,1,16'h0200);
      v(1,1,1, 3,0,0,3'b100,  0,0,0,0,0, 0,1,16'h0008);
      v(1,1,0, 0,0,0,3'b000,  0,0,0,0,0, 0,0,16'h0008);
      v(1,1,0, 0,0,0,3'b000,  0,0,0,0,0, 0,0,16'h0000);
      // unused operands never stall
      v(1,0,1, 0,0,0,3'b000,  3,1,0,0,0, 0,1,16'h0000);
      v(1,0,1, 3,3,3,3'b000,  0,0,0,0,0, 0,1,16'h0008);
      v(1,0,0, 0,0,0,3'b000,  0,0,0,0,0, 0,0,16'h0008);
      v(1,0,0, 0,0,0,3'b000,  0,0,0,0,0, 0,0,16'h0000);
      // freeze holds the load countdown
      v(1,1,1, 0,0,0,3'b000,  4,1,1,0,0, 0,1,16'h0000);
      v(1,1,1, 0,4,0,3'b010, 10,1,0,1,0, 1,0,16'h0010);
      v(1,1,1, 0,4,0,3'b010, 10,1,0,1,0, 1,0,16'h0010);
      v(1,1,1, 0,4,0,3'b010, 10,1,0,1,0, 1,0,16'h0010);
      v(1,1,1, 0,4,0,3'b010, 10,1,0,0,0, 1,0,16'h0010);
      v(1,1,1, 0,4,0,3'b010, 10,1,0,0,0, 0,1,16'h0010);
      v(1,1,0, 0,0,0,3'b000,  0,0,0,0,0, 0,0,16'h0400);
      v(1,1,0, 0,0,0,3'b000,  0,0,0,0,0, 0,0,16'h0400);
      v(1,1,0, 0,0,0,3'b000,  0,0,0,0,0, 0,0,16'h0000);
      // frozen issue is not recorded
      v(1,1,1, 0,0,0,3'b000, 11,1,0,1,0, 0,0,16'h0000);
      v(1,1,0, 0,0,0,3'b000,  0,0,0,0,0, 0,0,16'h0000);
      // flush blocks recording; in-flight producer keeps counting
      v(1,0,1, 0,0,0,3'b000, 14,1,0,0,0, 0,1,16'h0000);
      v(1,0,1, 0,0,0,3'b000,  5,1,0,0,1, 0,0,16'h4000);
      v(1,0,0, 0,0,0,3'b000,  0,0,0,0,0, 0,0,16'h4000);
      v(1,0,0, 0,0,0,3'b000,  0,0,0,0,0, 0,0,16'h0000);
      // back-to-back writes to r6 reload the countdown
      v(1,1,1, 0,0,0,3'b000,  6,1,0,0,0, 0,1,16'h0000);
      v(1,1,1, 0,0,0,3'b000,  6,1,0,0,0, 0,1,16'h0040);
      v(1,0,1, 0,0,6,3'b001,  0,0,0,0,0, 1,0,16'h0040);
      v(1,0,1, 0,0,6,3'b001,  0,0,0,0,0, 1,0,16'h0040);
      v(1,0,1, 0,0,6,3'b001,  0,0,0,0,0, 0,1,16'h0000);
      // source equals destination: no self-stall
      v(1,0,1, 0,0,12,3'b001, 12,1,0,0,0, 0,1,16'h0000);
      v(1,0,0, 0,0,0,3'b000,  0,0,0,0,0, 0,0,16'h1000);
      v(1,0,0, 0,0,0,3'b000,  0,0,0,0,0, 0,0,16'h1000);
      v(1,0,0, 0,0,0,3'b000,  0,0,0,0,0, 0,0,16'h0000);
      // forwarding dropped after an ALU issue
      v(1,1,1, 0,0,0,3'b000,  7,1,0,0,0, 0,1,16'h0000);
      v(1,0,1, 0,0,7,3'b001,  0,0,0,0,0, 1,0,16'h0080);
      v(1,0,1, 0,0,7,3'b001,  0,0,0,0,0, 1,0,16'h0080);
      v(1,0,1, 0,0,7,3'b001,  0,0,0,0,0, 0,1,16'h0000);
      // forwarding raised mid-stall releases the reader
      v(1,0,1, 0,0,0,3'b000, 13,1,0,0,0, 0,1,16'h0000);
      v(1,0,1, 0,13,0,3'b010, 0,0,0,0,0, 1,0,16'h2000);
      v(1,1,1, 0,13,0,3'b010, 0,0,0,0,0, 0,1,16'h2000);
      v(1,1,0, 0,0,0,3'b000,  0,0,0,0,0, 0,0,16'h0000);
      // r15 is an ordinary register
      v(1,0,1, 0,0,0,3'b000, 15,1,0,0,0, 0,1,16'h0000);
      v(1,0,1, 15,0,0,3'b100, 0,0,0,0,0, 1,0,16'h8000);
      v(1,0,1, 15,0,0,3'b100, 0,0,0,0,0, 1,0,16'h8000);
      v(1,0,1, 15,0,0,3'b100, 0,0,0,0,0, 0,1,16'h0000);
      // reset in flight clears the scoreboard
      v(1,0,1, 0,0,0,3'b000,  9,1,0,0,0, 0,1,16'h0000);
      v(0,0,1, 0,0,9,3'b001,  0,0,0,0,0, 0,0,16'h0000);
      v(1,0,1, 0,0,9,3'b001,  0,0,0,0,0, 0,1,16'h0000);

      t = '0;
      drive(t);
      repeat (2) @(negedge clk);

      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge clk);
         drive(vecs[k]);
         #1;
         if (!vecs[k].rst) stat_exp = 0;
         chk($sformatf("v%0d hazard", k), 32'(hazard_detected), 32'(vecs[k].hz));
         chk($sformatf("v%0d fire", k),   32'(issue_fire),      32'(vecs[k].fire));
         chk($sformatf("v%0d busy", k),   32'(busy_vec),        32'(vecs[k].busy));
         chk($sformatf("v%0d stats", k),  stall_cycles,         STATS ? 32'(stat_exp) : 32'd0);
         if (vecs[k].rst && vecs[k].iv && vecs[k].hz && !vecs[k].frz) stat_exp++;
      end

      // asynchronous reset with r3 in flight
      @(negedge clk);
      t = '0; t.rst = 1'b1; t.iv = 1'b1; t.dest = 4'd3; t.wb = 1'b1;
      drive(t);
      @(negedge clk);
      t.wb = 1'b0; t.dest = 4'd0; t.s0 = 4'd3; t.used = 3'b001;
      drive(t);
      #1;
      chk("rst pre hazard", 32'(hazard_detected), 32'd1);
      chk("rst pre busy",   32'(busy_vec),        32'h0008);
      rst = 1'b0;
      #1;
      chk("rst busy",   32'(busy_vec),        32'd0);
      chk("rst hazard", 32'(hazard_detected), 32'd0);
      chk("rst fire",   32'(issue_fire),      32'd0);
      chk("rst stats",  stall_cycles,         32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("post rst hazard", 32'(hazard_detected), 32'd0);
      chk("post rst fire",   32'(issue_fire),      32'd1);

      // stall lengths for the four producer/forwarding combinations
      stall_run(1'b0, 1'b0, stalls, tmo);
      chk("nofw alu stalls", 32'(stalls), 32'd2);
      chk("nofw alu timeout", 32'(tmo), 32'd0);
      stall_run(1'b0, 1'b1, stalls, tmo);
      chk("nofw load stalls", 32'(stalls), 32'd2);
      chk("nofw load timeout", 32'(tmo), 32'd0);
      stall_run(1'b1, 1'b1, stalls, tmo);
      chk("fw load stalls", 32'(stalls), 32'd1);
      chk("fw load timeout", 32'(tmo), 32'd0);
      stall_run(1'b1, 1'b0, stalls, tmo);
      chk("fw alu stalls", 32'(stalls), 32'd0);
      chk("fw alu timeout", 32'(tmo), 32'd0);
      chk("stats total", stall_cycles, STATS ? 32'd5 : 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
